multi_issue_engine: RTL and testbench
=====================================

MULTI_ISSUE_ENGINE -- requirements
Module: multi_issue_engine

Interface
REQ-001 SHALL have parameter ISSUE_WIDTH, default 2, meaning number of decode slots examined per cycle (legal 2..4).
REQ-002 SHALL have parameter LOAD_LAT, default 2, meaning cycles after load issue before its destination may be consumed (legal 1..7).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port flush  input  1  pipeline flush (exception/mispredict).
REQ-006 SHALL have port backend_stall  input  1  downstream cannot accept a group.
REQ-007 SHALL have port fifo_count  input  3  valid instructions available in the fetch FIFO.
REQ-008 SHALL have per-slot packed ports, all indexed [ISSUE_WIDTH-1:0]: slot_rs/slot_rt/slot_dest (5 each), slot_uses_rt, slot_wb_en, slot_mem_type (2, MEM_* encoding), slot_is_branch, slot_priv, slot_hilo; all input; slot 0 is oldest.
REQ-009 SHALL have port issue_en  output  ISSUE_WIDTH  per-slot issue grant, combinational.
REQ-010 SHALL have port issue_count  output  3  number of set bits in issue_en.
REQ-011 SHALL have port multi_issue_cnt  output  32  count of cycles with issue_count >= 2, wraps at 2^32.
REQ-012 SHALL have port hazard_stall_cnt  output  32  count of cycles slot 0 blocked only by scoreboard, wraps.

Function
REQ-013 SHALL keep a scoreboard: one 3-bit countdown per architectural register 1..31; register 0 never busy.
REQ-014 SHALL grant slot 0 iff fifo_count>=1, !backend_stall, !flush, and neither slot_rs[0] nor (slot_uses_rt[0] ? slot_rt[0]) has a nonzero countdown.
REQ-015 SHALL grant slot i>0 iff slot i-1 granted, fifo_count>i, slot i passes REQ-014 scoreboard check, slot i has mem_type==MEM_NONE, !is_branch, !priv, !hilo, and every earlier slot has !priv and !hilo.
REQ-016 SHALL block slot i>0 on intra-group RAW: any earlier slot j with wb_en, dest!=0, and dest==rs[i] or (uses_rt[i] and dest==rt[i]).
REQ-017 SHALL block slot i>0 on intra-group WAW: earlier slot j with wb_en, dest!=0, dest==slot_dest[i] and slot_wb_en[i].
REQ-018 SHALL make issue_en a contiguous prefix mask (e.g. 2'b10 never produced).
REQ-019 SHALL, when slot 0 is granted with mem_type==MEM_LOAD, wb_en and dest!=0, load countdown[dest]=LOAD_LAT at the next edge.
REQ-020 SHALL decrement every nonzero countdown by 1 each cycle with !backend_stall; hold when backend_stall.
REQ-021 SHALL, on simultaneous load-set and decrement of the same register, apply the set (LOAD_LAT) only.
REQ-022 SHALL, on flush, clear all countdowns at the next edge and force issue_en=0 in the flush cycle.
REQ-023 SHALL increment hazard_stall_cnt when slot 0 is valid (fifo_count>=1), !backend_stall, !flush, and blocked only by REQ-014 scoreboard term.
REQ-024 SHALL never set issue_en bits when fifo_count==0.

Reset
REQ-025 SHALL, with rst high at an edge, clear all countdowns and both counters to 0; rst overrides flush and load-set.
REQ-026 SHALL drive issue_en=0 and issue_count=0 in any cycle rst is high.
REQ-027 SHALL allow reset mid-countdown: next cycle after release all registers read not busy.

Structure
REQ-028 SHALL take MEM_NONE/MEM_LOAD/MEM_STORE encodings from common.vh.
REQ-029 SHALL place default ISSUE_WIDTH/LOAD_LAT and a slot-info struct typedef in package issue_pkg.
REQ-030 SHALL implement the countdown array as sub-module issue_scoreboard (set port, stall, clear, 2*ISSUE_WIDTH read ports).

Verification
REQ-031 SHALL test: W=2, fifo_count=3, independent ALU ops $1<-$2,$3 and $4<-$5,$6 -> issue_en=2'b11, multi_issue_cnt +1.
REQ-032 SHALL test: slot0 writes $8, slot1 reads rt=$8 with uses_rt=1 -> issue_en=2'b01; same with uses_rt=0 and rs=$9 -> 2'b11.
REQ-033 SHALL test: LOAD_LAT=2, load $5 issued cycle 0, consumer of $5 in slot 0 cycles 1..2 -> issue_en=0 and hazard_stall_cnt +2; cycle 3 -> granted.
REQ-034 SHALL test: load $5 then backend_stall for 3 cycles -> countdown held at 2, consumer blocked until 2 unstalled cycles pass.
REQ-035 SHALL test: load $5 issued, flush next cycle -> issue_en=0 that cycle, consumer of $5 granted the cycle after.
REQ-036 SHALL test: W=4, fifo_count=2, four independent ops -> issue_en=4'b0011; slot1 priv -> 4'b0001.

Source files
------------

// File: rtl/issue_pkg.sv
// Shared types and defaults for the multi-issue decode engine.
package issue_pkg;

  localparam int DEFAULT_ISSUE_WIDTH = 2;
  localparam int DEFAULT_LOAD_LAT    = 2;

  // Memory-access class of a decoded instruction.
  localparam logic [1:0] MEM_NONE  = 2'd0;
  localparam logic [1:0] MEM_LOAD  = 2'd1;
  localparam logic [1:0] MEM_STORE = 2'd2;

  // Everything the issue logic needs to know about one decode slot.
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
    logic       uses_rt;
    logic       wb_en;
    logic [1:0] mem_type;
    logic       is_branch;
    logic       priv;
    logic       hilo;
  } slot_info_t;

  // True when slot s produces a result in architectural register r (never $0).
  function automatic logic writes_reg(input slot_info_t s, input logic [4:0] r);
    return s.wb_en && (s.dest != 5'd0) && (s.dest == r);
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Per-register load-use countdown array with multi-port busy lookup.
module issue_scoreboard
  import issue_pkg::*;
#(
  parameter int NUM_RD   = 4,
  parameter int LOAD_LAT = DEFAULT_LOAD_LAT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   stall,
  input  logic                   set_en,
  input  logic [4:0]             set_addr,
  input  logic [NUM_RD-1:0][4:0] rd_addr,
  output logic [NUM_RD-1:0]      rd_busy
);

  logic [2:0] cnt_q [32];
  logic [2:0] cnt_d [32];

  // Next countdown: decrement when the backend moves, a new load overrides, flush wipes all.
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      cnt_d[r] = cnt_q[r];
      if (!stall && (cnt_q[r] != 3'd0)) begin
        cnt_d[r] = cnt_q[r] - 3'd1;
      end
      if (set_en && (set_addr == 5'(r))) begin
        cnt_d[r] = 3'(LOAD_LAT);
      end
      if (clear) begin
        cnt_d[r] = 3'd0;
      end
    end
    // $0 is hard-wired and can never be waited on.
    cnt_d[0] = 3'd0;
  end

  // Countdown state; reset dominates flush and load-set.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= 3'd0;
      end
    end else begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    assign rd_busy[gi] = (cnt_q[rd_addr[gi]] != 3'd0);
  end

endmodule

// File: rtl/multi_issue_engine.sv
// In-order multi-issue grant logic with load-use scoreboard and perf counters.
module multi_issue_engine
  import issue_pkg::*;
#(
  parameter int ISSUE_WIDTH = DEFAULT_ISSUE_WIDTH,
  parameter int LOAD_LAT    = DEFAULT_LOAD_LAT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        backend_stall,
  input  logic [2:0]                  fifo_count,
  input  logic [ISSUE_WIDTH-1:0][4:0] slot_rs,
  input  logic [ISSUE_WIDTH-1:0][4:0] slot_rt,
  input  logic [ISSUE_WIDTH-1:0][4:0] slot_dest,
  input  logic [ISSUE_WIDTH-1:0]      slot_uses_rt,
  input  logic [ISSUE_WIDTH-1:0]      slot_wb_en,
  input  logic [ISSUE_WIDTH-1:0][1:0] slot_mem_type,
  input  logic [ISSUE_WIDTH-1:0]      slot_is_branch,
  input  logic [ISSUE_WIDTH-1:0]      slot_priv,
  input  logic [ISSUE_WIDTH-1:0]      slot_hilo,
  output logic [ISSUE_WIDTH-1:0]      issue_en,
  output logic [2:0]                  issue_count,
  output logic [31:0]                 multi_issue_cnt,
  output logic [31:0]                 hazard_stall_cnt
);

  localparam int NUM_RD = 2 * ISSUE_WIDTH;

  slot_info_t               slot [ISSUE_WIDTH];
  logic [NUM_RD-1:0][4:0]   rd_addr;
  logic [NUM_RD-1:0]        rd_busy;
  logic [ISSUE_WIDTH-1:0]   grant;
  logic                     chain_c;
  logic                     ok_c;
  logic [2:0]               count_c;
  logic                     hazard_c;
  logic                     load_set;
  logic [31:0]              multi_issue_cnt_q, multi_issue_cnt_d;
  logic [31:0]              hazard_stall_cnt_q, hazard_stall_cnt_d;

  // Slot i looks up its rs on port 2i and its rt on port 2i+1.
  for (genvar gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_slot
    assign slot[gi] = '{rs: slot_rs[gi], rt: slot_rt[gi], dest: slot_dest[gi],
                        uses_rt: slot_uses_rt[gi], wb_en: slot_wb_en[gi],
                        mem_type: slot_mem_type[gi], is_branch: slot_is_branch[gi],
                        priv: slot_priv[gi], hilo: slot_hilo[gi]};
    assign rd_addr[2*gi]   = slot_rs[gi];
    assign rd_addr[2*gi+1] = slot_rt[gi];
  end

  // Walk slots oldest-first; the first refusal ends the group so the grant is always a prefix.
  always_comb begin
    grant   = '0;
    count_c = 3'd0;
    ok_c    = 1'b0;
    chain_c = !rst && !flush && !backend_stall;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      ok_c = (int'(fifo_count) > i) && !rd_busy[2*i] && !(slot[i].uses_rt && rd_busy[2*i+1]);
      if (i > 0) begin
        // Younger slots must be plain ALU ops; memory, branch, priv and hilo go alone or first.
        ok_c = ok_c && (slot[i].mem_type == MEM_NONE) && !slot[i].is_branch &&
               !slot[i].priv && !slot[i].hilo;
        for (int j = 0; j < i; j++) begin
          if (slot[j].priv || slot[j].hilo) ok_c = 1'b0;
          if (writes_reg(slot[j], slot[i].rs)) ok_c = 1'b0;
          if (slot[i].uses_rt && writes_reg(slot[j], slot[i].rt)) ok_c = 1'b0;
          if (slot[i].wb_en && writes_reg(slot[j], slot[i].dest)) ok_c = 1'b0;
        end
      end
      chain_c  = chain_c && ok_c;
      grant[i] = chain_c;
      count_c  = count_c + {2'b00, chain_c};
    end
  end

  assign issue_en    = grant;
  assign issue_count = count_c;

  // Slot 0 present and otherwise issuable, but waiting on a pending load result.
  assign hazard_c = (fifo_count != 3'd0) && !backend_stall && !flush &&
                    (rd_busy[0] || (slot[0].uses_rt && rd_busy[1]));

  assign load_set = grant[0] && (slot[0].mem_type == MEM_LOAD) &&
                    slot[0].wb_en && (slot[0].dest != 5'd0);

  issue_scoreboard #(
    .NUM_RD   (NUM_RD),
    .LOAD_LAT (LOAD_LAT)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .stall    (backend_stall),
    .set_en   (load_set),
    .set_addr (slot[0].dest),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy)
  );

  // Performance counters advance freely and wrap at 2^32.
  always_comb begin
    multi_issue_cnt_d  = multi_issue_cnt_q + {31'd0, (count_c >= 3'd2)};
    hazard_stall_cnt_d = hazard_stall_cnt_q + {31'd0, hazard_c};
  end

  // Counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      multi_issue_cnt_q  <= 32'd0;
      hazard_stall_cnt_q <= 32'd0;
    end else begin
      multi_issue_cnt_q  <= multi_issue_cnt_d;
      hazard_stall_cnt_q <= hazard_stall_cnt_d;
    end
  end

  assign multi_issue_cnt  = multi_issue_cnt_q;
  assign hazard_stall_cnt = hazard_stall_cnt_q;

endmodule

// File: tb/tb_multi_issue_engine.sv
// Scoreboard bench: a 2-wide (LOAD_LAT=2) and a 4-wide (LOAD_LAT=3) engine
// share stimulus; a reference model predicts each cycle, a monitor compares.
module tb_multi_issue_engine;
  import issue_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, flush, backend_stall;
  logic [2:0]      fifo_count;
  logic [3:0][4:0] rs_v, rt_v, dest_v;
  logic [3:0]      urt_v, wb_v, br_v, priv_v, hilo_v;
  logic [3:0][1:0] mem_v;

  logic [1:0]  en2;
  logic [2:0]  cnt2;
  logic [31:0] mi2, hz2;
  logic [3:0]  en4;
  logic [2:0]  cnt4;
  logic [31:0] mi4, hz4;

  multi_issue_engine #(.ISSUE_WIDTH(2), .LOAD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .backend_stall(backend_stall),
    .fifo_count(fifo_count),
    .slot_rs(rs_v[1:0]), .slot_rt(rt_v[1:0]), .slot_dest(dest_v[1:0]),
    .slot_uses_rt(urt_v[1:0]), .slot_wb_en(wb_v[1:0]), .slot_mem_type(mem_v[1:0]),
    .slot_is_branch(br_v[1:0]), .slot_priv(priv_v[1:0]), .slot_hilo(hilo_v[1:0]),
    .issue_en(en2), .issue_count(cnt2), .multi_issue_cnt(mi2), .hazard_stall_cnt(hz2)
  );

  multi_issue_engine #(.ISSUE_WIDTH(4), .LOAD_LAT(3)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .backend_stall(backend_stall),
    .fifo_count(fifo_count),
    .slot_rs(rs_v), .slot_rt(rt_v), .slot_dest(dest_v),
    .slot_uses_rt(urt_v), .slot_wb_en(wb_v), .slot_mem_type(mem_v),
    .slot_is_branch(br_v), .slot_priv(priv_v), .slot_hilo(hilo_v),
    .issue_en(en4), .issue_count(cnt4), .multi_issue_cnt(mi4), .hazard_stall_cnt(hz4)
  );

  // Reference model state: index 0 = 2-wide, 1 = 4-wide.
  // rem[m][r] = unstalled cycles still to pass before register r may be read.
  int          rem   [2][32];
  logic [31:0] mi_m  [2];
  logic [31:0] hz_m  [2];

  typedef struct {
    logic [3:0]  en;
    logic [2:0]  cnt;
    logic [31:0] mi;
    logic [31:0] hz;
    int          dir;
  } exp_t;

  exp_t  q2[$];
  exp_t  q4[$];
  string name_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int step_no  = 0;

  function automatic bit reg_ready(int m, logic [4:0] r);
    return (r == 5'd0) || (rem[m][r] == 0);
  endfunction

  function automatic bit src_ready(int m, int i);
    return reg_ready(m, rs_v[i]) && (!urt_v[i] || reg_ready(m, rt_v[i]));
  endfunction

  function automatic logic [3:0] model_grant(int m);
    int         w = (m == 0) ? 2 : 4;
    logic [3:0] g = 4'd0;
    bit         ok;
    if (rst || flush || backend_stall) return 4'd0;
    for (int i = 0; i < w; i++) begin
      ok = (int'(fifo_count) > i) && src_ready(m, i);
      if (i > 0) begin
        if (mem_v[i] != MEM_NONE || br_v[i] || priv_v[i] || hilo_v[i]) ok = 0;
        for (int j = 0; j < i; j++) begin
          if (priv_v[j] || hilo_v[j]) ok = 0;
          if (wb_v[j] && dest_v[j] != 5'd0) begin
            if (dest_v[j] == rs_v[i]) ok = 0;
            if (urt_v[i] && dest_v[j] == rt_v[i]) ok = 0;
            if (wb_v[i] && dest_v[j] == dest_v[i]) ok = 0;
          end
        end
      end
      if (!ok) break;
      g[i] = 1'b1;
    end
    return g;
  endfunction

  task automatic model_advance(int m, logic [3:0] g);
    int lat = (m == 0) ? 2 : 3;
    if (rst) begin
      for (int r = 0; r < 32; r++) rem[m][r] = 0;
      mi_m[m] = 32'd0;
      hz_m[m] = 32'd0;
      return;
    end
    if ($countones(g) >= 2) mi_m[m] = mi_m[m] + 32'd1;
    if (fifo_count != 0 && !backend_stall && !flush && !src_ready(m, 0)) hz_m[m] = hz_m[m] + 32'd1;
    if (flush) begin
      for (int r = 0; r < 32; r++) rem[m][r] = 0;
    end else begin
      if (!backend_stall)
        for (int r = 0; r < 32; r++) if (rem[m][r] > 0) rem[m][r] = rem[m][r] - 1;
      if (g[0] && mem_v[0] == MEM_LOAD && wb_v[0] && dest_v[0] != 5'd0) rem[m][dest_v[0]] = lat;
    end
  endtask

  // Inputs are already applied; predict this cycle, queue it, advance the model, cross one edge.
  task automatic step(input string name, input int d2, input int d4);
    exp_t e;
    logic [3:0] g;
    for (int m = 0; m < 2; m++) begin
      g     = model_grant(m);
      e.en  = g;
      e.cnt = 3'($countones(g));
      e.mi  = mi_m[m];
      e.hz  = hz_m[m];
      e.dir = (m == 0) ? d2 : d4;
      if (m == 0) q2.push_back(e); else q4.push_back(e);
      model_advance(m, g);
    end
    name_q.push_back(name);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string what, input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s [%s step %0d]: got %0h expected %0h", what, name, step_no, got, exp);
    end
  endtask

  // Monitor: outputs are stable mid-cycle; compare against the oldest queued prediction.
  initial begin
    exp_t  a, b;
    string nm;
    forever begin
      @(negedge clk);
      if (q2.size() > 0 && q4.size() > 0) begin
        a  = q2.pop_front();
        b  = q4.pop_front();
        nm = name_q.pop_front();
        chk("en_w2",  nm, {30'd0, en2}, {28'd0, a.en});
        chk("cnt_w2", nm, {29'd0, cnt2}, {29'd0, a.cnt});
        chk("mi_w2",  nm, mi2, a.mi);
        chk("hz_w2",  nm, hz2, a.hz);
        chk("en_w4",  nm, {28'd0, en4}, {28'd0, b.en});
        chk("cnt_w4", nm, {29'd0, cnt4}, {29'd0, b.cnt});
        chk("mi_w4",  nm, mi4, b.mi);
        chk("hz_w4",  nm, hz4, b.hz);
        if (a.dir >= 0) chk("dir_w2", nm, {30'd0, en2}, 32'(a.dir));
        if (b.dir >= 0) chk("dir_w4", nm, {28'd0, en4}, 32'(b.dir));
        $display("step %0d %s: w2 en=%b cnt=%0d mi=%0d hz=%0d | w4 en=%b cnt=%0d mi=%0d hz=%0d",
                 step_no, nm, en2, cnt2, mi2, hz2, en4, cnt4, mi4, hz4);
        step_no++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic set_slot(int i, int rs, int rt, int dest, bit urt, bit wb, logic [1:0] mem);
    rs_v[i] = 5'(rs); rt_v[i] = 5'(rt); dest_v[i] = 5'(dest);
    urt_v[i] = urt; wb_v[i] = wb; mem_v[i] = mem;
    br_v[i] = 1'b0; priv_v[i] = 1'b0; hilo_v[i] = 1'b0;
  endtask

  task automatic clear_slots();
    for (int i = 0; i < 4; i++) set_slot(i, 0, 0, 0, 0, 0, MEM_NONE);
  endtask

  task automatic idle(int n);
    fifo_count = 3'd0;
    for (int k = 0; k < n; k++) step("idle", 0, 0);
  endtask

  initial begin
    int rv;
    rst = 1'b1; flush = 1'b0; backend_stall = 1'b0; fifo_count = 3'd0;
    clear_slots();
    @(posedge clk);
    #1;

    // Reset with work present: nothing issues.
    fifo_count = 3'd3;
    set_slot(0, 2, 3, 1, 1, 1, MEM_NONE);
    step("reset", 0, 0);
    step("reset", 0, 0);
    rst = 1'b0;

    // Two independent ALU ops pair up.
    clear_slots();
    fifo_count = 3'd3;
    set_slot(0, 2, 3, 1, 1, 1, MEM_NONE);
    set_slot(1, 5, 6, 4, 1, 1, MEM_NONE);
    step("indep_alu", 3, 7);
    step("indep_alu", 3, 7);

    // Intra-group RAW through rt, then rt not used.
    fifo_count = 3'd2;
    set_slot(0, 2, 3, 8, 1, 1, MEM_NONE);
    set_slot(1, 10, 8, 11, 1, 1, MEM_NONE);
    step("raw_rt", 1, 1);
    set_slot(1, 9, 8, 11, 0, 1, MEM_NONE);
    step("raw_rt_unused", 3, 3);
    // Intra-group WAW.
    set_slot(1, 9, 10, 8, 1, 1, MEM_NONE);
    step("waw", 1, 1);

    // Load-use: LOAD_LAT=2 on the narrow engine, 3 on the wide one.
    clear_slots();
    fifo_count = 3'd1;
    set_slot(0, 2, 0, 5, 0, 1, MEM_LOAD);
    step("load", 1, 1);
    set_slot(0, 5, 0, 6, 0, 1, MEM_NONE);
    step("use_c1", 0, 0);
    step("use_c2", 0, 0);
    step("use_c3", 1, 0);
    step("use_c4", 1, 1);
    idle(3);

    // Load then stall: countdown holds while stalled.
    fifo_count = 3'd1;
    set_slot(0, 2, 0, 5, 0, 1, MEM_LOAD);
    step("load_st", 1, 1);
    set_slot(0, 5, 0, 6, 0, 1, MEM_NONE);
    backend_stall = 1'b1;
    step("stall1", 0, 0);
    step("stall2", 0, 0);
    step("stall3", 0, 0);
    backend_stall = 1'b0;
    step("unst1", 0, 0);
    step("unst2", 0, 0);
    step("unst3", 1, 0);
    idle(3);

    // Flush wipes pending loads.
    fifo_count = 3'd1;
    set_slot(0, 2, 0, 5, 0, 1, MEM_LOAD);
    step("load_fl", 1, 1);
    set_slot(0, 5, 0, 6, 0, 1, MEM_NONE);
    flush = 1'b1;
    step("flush", 0, 0);
    flush = 1'b0;
    step("after_flush", 1, 1);

    // Wide engine limited by fifo_count, and priv serialising.
    clear_slots();
    fifo_count = 3'd2;
    set_slot(0, 2, 3, 1, 1, 1, MEM_NONE);
    set_slot(1, 5, 6, 4, 1, 1, MEM_NONE);
    set_slot(2, 8, 9, 7, 1, 1, MEM_NONE);
    set_slot(3, 11, 12, 10, 1, 1, MEM_NONE);
    step("fifo2", 3, 3);
    fifo_count = 3'd4;
    step("fifo4", 3, 15);
    fifo_count = 3'd2;
    priv_v[1] = 1'b1;
    step("priv1", 1, 1);
    priv_v[1] = 1'b0;
    fifo_count = 3'd0;
    step("empty", 0, 0);

    // Reset in the middle of a countdown.
    clear_slots();
    fifo_count = 3'd1;
    set_slot(0, 2, 0, 5, 0, 1, MEM_LOAD);
    step("load_rst", 1, 1);
    rst = 1'b1;
    set_slot(0, 5, 0, 6, 0, 1, MEM_NONE);
    step("rst_mid", 0, 0);
    rst = 1'b0;
    step("post_rst", 1, 1);

    // Randomised traffic on a small register set so hazards are frequent.
    for (int k = 0; k < 500; k++) begin
      rst           = ($urandom_range(0, 99) == 0);
      flush         = ($urandom_range(0, 99) < 5);
      backend_stall = ($urandom_range(0, 99) < 15);
      fifo_count    = 3'($urandom_range(0, 7));
      for (int i = 0; i < 4; i++) begin
        rs_v[i]   = 5'($urandom_range(0, 7));
        rt_v[i]   = 5'($urandom_range(0, 7));
        dest_v[i] = 5'($urandom_range(0, 7));
        urt_v[i]  = 1'($urandom_range(0, 1));
        wb_v[i]   = ($urandom_range(0, 3) != 0);
        rv        = $urandom_range(0, 7);
        mem_v[i]  = (rv == 0) ? MEM_LOAD : (rv == 1) ? MEM_STORE : MEM_NONE;
        br_v[i]   = ($urandom_range(0, 9) == 0);
        priv_v[i] = ($urandom_range(0, 15) == 0);
        hilo_v[i] = ($urandom_range(0, 15) == 0);
      end
      step("rand", -1, -1);
    end

    @(negedge clk);
    #1;
    chk("queue_drained", "end", 32'(q2.size() + q4.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
